// File: rtl/viking_capture.sv
// Mono pixel capture: packs serial pixels into 64-bit words, queues them in a small
// FIFO and writes one word to RAM per owned bus slot (slot 1), address advancing by 4.
module viking_capture #(
    parameter logic [22:0] BASE       = 23'h600000,
    parameter logic [22:0] BASE_HI    = 23'h740000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic        himem,
    input  logic        clk_8_en,
    input  logic [1:0]  bus_cycle,
    input  logic        pix_in,
    input  logic        pix_de,
    input  logic        pix_vs_n,
    output logic [22:0] addr,
    output logic        write,
    output logic [63:0] data,
    output logic        overflow,
    output logic        frame_done
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic          vs_q, de_q, slot_q, en_q, armed;
    logic [63:0]   sr;
    logic [5:0]    cnt;
    logic [AW-1:0] rp, wp;
    logic [AW:0]   count;
    logic [63:0]   mem [FIFO_DEPTH];

    logic          vs_fall, slot, slot_entry, full_push, part_push;
    logic          push, pop, commit, accept, drop, empty, full;
    logic [63:0]   sr_next, aligned, push_word;

    // First captured pixel ends up at data[15]; halfwords are swapped end-for-end.
    function automatic logic [63:0] reorder(input logic [63:0] s);
        return {s[15:0], s[31:16], s[47:32], s[63:48]};
    endfunction

    assign vs_fall    = vs_q & ~pix_vs_n;
    assign slot       = (bus_cycle == 2'd1);
    assign slot_entry = slot & ~slot_q;
    assign sr_next    = {sr[62:0], pix_in};
    assign aligned    = sr << (7'd64 - {1'b0, cnt});
    assign full_push  = pix_de & (cnt == 6'd63);
    assign part_push  = ~pix_de & de_q & (cnt != 6'd0);
    assign push_word  = full_push ? reorder(sr_next) : reorder(aligned);
    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);

    // A frame start overrides everything in its pclk: no push, no commit.
    assign push   = (full_push | part_push) & ~vs_fall;
    assign commit = slot & armed & clk_8_en & ~en_q & ~vs_fall;
    assign pop    = commit;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    assign write = slot & armed;
    assign data  = mem[rp];

    // slot_q resets high so a reset released mid-slot waits for the next slot entry.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
            slot_q     <= 1'b1;
            en_q       <= 1'b0;
            sr         <= '0;
            cnt        <= '0;
            armed      <= 1'b0;
            addr       <= BASE;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            rp         <= '0;
            wp         <= '0;
            count      <= '0;
        end else begin
            vs_q       <= pix_vs_n;
            de_q       <= pix_de;
            slot_q     <= slot;
            en_q       <= clk_8_en;
            frame_done <= vs_fall;
            if (vs_fall) begin
                addr     <= himem ? BASE_HI : BASE;
                sr       <= '0;
                cnt      <= '0;
                armed    <= 1'b0;
                overflow <= 1'b0;
                rp       <= '0;
                wp       <= '0;
                count    <= '0;
            end else begin
                if (pix_de) begin
                    sr  <= sr_next;
                    cnt <= cnt + 6'd1;
                end else if (part_push) begin
                    cnt <= '0;
                end
                if (slot_entry) begin
                    armed <= ~empty;
                end else if (commit | ~slot) begin
                    armed <= 1'b0;
                end
                if (commit) begin
                    addr <= addr + 23'd4;
                    rp   <= rp + 1'b1;
                end
                if (accept) begin
                    wp <= wp + 1'b1;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                count <= count + (AW+1)'(accept) - (AW+1)'(pop);
            end
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[wp] <= push_word;
        end
    end
endmodule

// File: tb/tb_viking_capture.sv
// Self-checking bench for viking_capture: directed vector table, hand-written
// corner sequences and random lines checked against a pixel-level reference model.
module tb_viking_capture;
    typedef struct { int n; logic [63:0] pix; logic [63:0] exp_data; } vec_t;
    typedef struct { logic [22:0] a; logic [63:0] d; } wr_t;

    logic        pclk = 1'b0;
    logic        reset_n, himem, clk_8_en, pix_in, pix_de, pix_vs_n;
    logic [1:0]  bus_cycle;
    logic [22:0] addr;
    logic        write;
    logic [63:0] data;
    logic        overflow, frame_done;

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  fd_cnt = 0;
    bit  bus_on = 1'b0;
    bit  w_last = 1'b0;
    logic [22:0] a_last;
    logic [63:0] d_last;
    wr_t wq[$];
    wr_t exq[$];
    vec_t vecs[7];

    viking_capture dut (
        .pclk(pclk), .reset_n(reset_n), .himem(himem), .clk_8_en(clk_8_en),
        .bus_cycle(bus_cycle), .pix_in(pix_in), .pix_de(pix_de), .pix_vs_n(pix_vs_n),
        .addr(addr), .write(write), .data(data), .overflow(overflow),
        .frame_done(frame_done)
    );

    always #4 pclk = ~pclk;

    initial begin
        #(8 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pixel k of a word lands at bit 16*(k/16) + 15 - k%16; pixel vector holds pixel k at bit 63-k.
    function automatic logic [63:0] pack(input logic [63:0] pv);
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < 64; k++) d[16 * (k / 16) + 15 - (k % 16)] = pv[63 - k];
        return d;
    endfunction

    task automatic observe();
        if (frame_done === 1'b1) fd_cnt++;
        if (write === 1'b1 && w_last) begin
            check("addr stable during write", addr, a_last);
            check("data stable during write", data, d_last);
        end
        if (write === 1'b1 && !w_last) wq.push_back('{addr, data});
        w_last = (write === 1'b1);
        a_last = addr;
        d_last = data;
    endtask

    // Slot n of 4 lasts 16 pclk; one clk_8_en pulse mid-slot.
    task automatic tick(input logic de, input logic px);
        @(negedge pclk);
        observe();
        pix_de    = de;
        pix_in    = px;
        bus_cycle = bus_on ? 2'((cyc >> 4) & 3) : 2'd0;
        clk_8_en  = ((cyc % 16) == 8);
        cyc++;
    endtask

    task automatic feed(input logic [63:0] pv, input int n);
        for (int k = 0; k < n; k++) tick(1'b1, pv[63 - k]);
    endtask

    task automatic start_frame(input logic hm);
        int fd0;
        fd0 = fd_cnt;
        himem = hm;
        pix_vs_n = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        pix_vs_n = 1'b1;
        tick(1'b0, 1'b0);
        check("frame_done single pulse", 64'(fd_cnt - fd0), 64'd1);
        check("frame start addr", addr, hm ? 23'h740000 : 23'h600000);
        wq.delete();
        exq.delete();
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (wq.size() < n && t < budget) begin
            tick(1'b0, 1'b0);
            t++;
        end
        total++;
        if (wq.size() < n) begin
            bad++;
            $display("FAIL %s: timeout with %0d writes, required %0d", name, wq.size(), n);
        end
    endtask

    task automatic align64();
        while ((cyc % 64) != 0) tick(1'b0, 1'b0);
    endtask

    task automatic rand_line(input int len, input logic [22:0] base);
        logic [63:0] pv;
        logic px;
        int k;
        pv = '0;
        k = 0;
        for (int i = 0; i < len; i++) begin
            px = 1'($urandom_range(0, 1));
            pv[63 - k] = px;
            k++;
            tick(1'b1, px);
            if (k == 64) begin
                exq.push_back('{base + 23'(4 * exq.size()), pack(pv)});
                pv = '0;
                k = 0;
            end
        end
        if (k != 0) exq.push_back('{base + 23'(4 * exq.size()), pack(pv)});
        repeat ($urandom_range(80, 120)) tick(1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] words[5];
        int t, s0, fd0, nl;
        logic hm;
        logic [22:0] base;

        vecs[0] = '{64, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA};
        vecs[1] = '{64, 64'hFFFF_0000_0000_0000, 64'h0000_0000_0000_FFFF};
        vecs[2] = '{10, 64'hFFC0_0000_0000_0000, 64'h0000_0000_0000_FFC0};
        vecs[3] = '{64, 64'h0123_4567_89AB_CDEF, 64'hCDEF_89AB_4567_0123};
        vecs[4] = '{20, 64'hDEAD_B000_0000_0000, 64'h0000_0000_B000_DEAD};
        vecs[5] = '{1,  64'h8000_0000_0000_0000, 64'h0000_0000_0000_8000};
        vecs[6] = '{63, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFE_FFFF_FFFF_FFFF};

        reset_n = 1'b0; himem = 1'b0; clk_8_en = 1'b0; bus_cycle = 2'd0;
        pix_in = 1'b0; pix_de = 1'b0; pix_vs_n = 1'b1;
        bus_on = 1'b1;
        repeat (5) tick(1'b0, 1'b0);
        check("reset addr", addr, 23'h600000);
        check("reset write", write, 1'b0);
        check("reset data", data, 64'd0);
        check("reset overflow", overflow, 1'b0);
        check("reset frame_done", frame_done, 1'b0);
        reset_n = 1'b1;
        repeat (4) tick(1'b0, 1'b0);

        foreach (vecs[i]) begin
            start_frame(1'b0);
            feed(vecs[i].pix, vecs[i].n);
            tick(1'b0, 1'b0);
            wait_writes(1, 300, $sformatf("vec%0d write", i));
            if (wq.size() > 0) begin
                check($sformatf("vec%0d addr", i), wq[0].a, 23'h600000);
                check($sformatf("vec%0d data", i), wq[0].d, vecs[i].exp_data);
            end
            repeat (40) tick(1'b0, 1'b0);
            check($sformatf("vec%0d next addr", i), addr, 23'h600004);
            check($sformatf("vec%0d write count", i), 64'(wq.size()), 64'd1);
        end

        // Partial word must clear the pixel counter for the next line.
        start_frame(1'b0);
        feed(64'hFFC0_0000_0000_0000, 10);
        tick(1'b0, 1'b0);
        feed(64'hAAAA_AAAA_AAAA_AAAA, 64);
        tick(1'b0, 1'b0);
        wait_writes(2, 400, "partial then full");
        if (wq.size() >= 2) begin
            check("partial word data", wq[0].d, 64'h0000_0000_0000_FFC0);
            check("after partial data", wq[1].d, 64'hAAAA_AAAA_AAAA_AAAA);
            check("after partial addr", wq[1].a, 23'h600004);
        end

        // Overflow: five words with the bus starved, FIFO holds four.
        bus_on = 1'b0;
        start_frame(1'b0);
        for (int w = 0; w < 5; w++) begin
            words[w] = {$urandom, $urandom};
            feed(words[w], 64);
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("overflow set", overflow, 1'b1);
        check("no write while starved", 64'(wq.size()), 64'd0);
        bus_on = 1'b1;
        wait_writes(4, 600, "overflow drain");
        for (int w = 0; w < 4; w++) begin
            if (w < wq.size()) begin
                check($sformatf("ovf word%0d data", w), wq[w].d, pack(words[w]));
                check($sformatf("ovf word%0d addr", w), wq[w].a, 23'h600000 + 23'(4 * w));
            end
        end
        repeat (300) tick(1'b0, 1'b0);
        check("dropped word absent", 64'(wq.size()), 64'd4);
        check("overflow sticky", overflow, 1'b1);
        start_frame(1'b0);
        check("overflow cleared by frame", overflow, 1'b0);

        // Frame start inside an armed slot.
        bus_on = 1'b0;
        start_frame(1'b0);
        feed({$urandom, $urandom}, 64);
        feed({$urandom, $urandom}, 64);
        tick(1'b0, 1'b0);
        align64();
        bus_on = 1'b1;
        t = 0;
        while (!w_last && t < 200) begin
            tick(1'b0, 1'b0);
            t++;
        end
        check("armed slot reached", w_last, 1'b1);
        fd0 = fd_cnt;
        himem = 1'b1;
        pix_vs_n = 1'b0;
        tick(1'b0, 1'b0);
        check("write drops on vs", write, 1'b0);
        pix_vs_n = 1'b1;
        repeat (3) tick(1'b0, 1'b0);
        check("vs in slot addr", addr, 23'h740000);
        check("vs in slot overflow", overflow, 1'b0);
        check("vs in slot frame_done", 64'(fd_cnt - fd0), 64'd1);
        s0 = wq.size();
        repeat (200) tick(1'b0, 1'b0);
        check("fifo flushed", 64'(wq.size()), 64'(s0));
        check("no commit after vs", addr, 23'h740000);

        // Reset mid-line with words queued and a write in progress.
        himem = 1'b0;
        bus_on = 1'b0;
        start_frame(1'b0);
        for (int i = 0; i < 3 * 64 + 20; i++) tick(1'b1, 1'($urandom_range(0, 1)));
        bus_on = 1'b1;
        t = 0;
        while (!(wq.size() >= 2 && w_last) && t < 400) begin
            tick(1'b1, 1'($urandom_range(0, 1)));
            t++;
        end
        check("second write reached", 64'(wq.size()), 64'd2);
        reset_n = 1'b0;
        pix_de = 1'b0;
        #1;
        check("async reset addr", addr, 23'h600000);
        check("async reset write", write, 1'b0);
        check("async reset data", data, 64'd0);
        check("async reset overflow", overflow, 1'b0);
        check("async reset frame_done", frame_done, 1'b0);
        repeat (5) tick(1'b0, 1'b0);
        t = 0;
        while (((cyc - 1) % 64) != 20 && t < 70) begin
            tick(1'b0, 1'b0);
            t++;
        end
        reset_n = 1'b1;
        wq.delete();
        repeat (200) tick(1'b0, 1'b0);
        check("no write after reset", 64'(wq.size()), 64'd0);
        feed(64'h0123_4567_89AB_CDEF, 64);
        tick(1'b0, 1'b0);
        wait_writes(1, 300, "post reset write");
        if (wq.size() > 0) begin
            check("post reset addr", wq[0].a, 23'h600000);
            check("post reset data", wq[0].d, 64'hCDEF_89AB_4567_0123);
        end

        // Random lines against the pixel-level model.
        for (int f = 0; f < 3; f++) begin
            hm = 1'($urandom_range(0, 1));
            base = hm ? 23'h740000 : 23'h600000;
            start_frame(hm);
            nl = $urandom_range(3, 5);
            for (int l = 0; l < nl; l++) rand_line($urandom_range(1, 200), base);
            wait_writes(exq.size(), 64 * exq.size() + 400, $sformatf("frame%0d drain", f));
            repeat (80) tick(1'b0, 1'b0);
            check($sformatf("frame%0d write count", f), 64'(wq.size()), 64'(exq.size()));
            for (int i = 0; i < exq.size(); i++) begin
                if (i < wq.size()) begin
                    check($sformatf("frame%0d word%0d addr", f, i), wq[i].a, exq[i].a);
                    check($sformatf("frame%0d word%0d data", f, i), wq[i].d, exq[i].d);
                end
            end
            check($sformatf("frame%0d overflow", f), overflow, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/viking_capture.md
VIKING_CAPTURE -- requirements
Module: viking_capture

Interface
REQ-001 SHALL have parameter BASE, default 23'h600000, word address of the capture buffer when himem=0.
REQ-002 SHALL have parameter BASE_HI, default 23'h740000, word address of the capture buffer when himem=1.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of 64-bit words buffered; power of two, minimum 2.
REQ-004 SHALL have ports:
  pclk       in   1   128 MHz pixel clock; the only clock
  reset_n    in   1   reset, asynchronous assert, active-low
  himem      in   1   select BASE_HI instead of BASE
  clk_8_en   in   1   8 MHz bus clock enable (pclk domain)
  bus_cycle  in   2   bus slot number; slot 1 is owned by this block
  pix_in     in   1   serial mono pixel, 1 = white
  pix_de     in   1   pixel valid qualifier
  pix_vs_n   in   1   vertical sync, active-low
  addr       out  23  RAM word address
  write      out  1   RAM write strobe
  data       out  64  RAM write data
  overflow   out  1   sticky: a word was dropped this frame
  frame_done out  1   one-pclk pulse at each vs_n falling edge
REQ-005 One clock, pclk; reset_n asynchronous active-low; no other clock or reset input.

Function
REQ-006 On every pclk with pix_de=1, pix_in SHALL be shifted into a 64-bit register at bit 0, existing contents moving toward bit 63; a 6-bit pixel counter SHALL increment.
REQ-007 When the 64th pixel shifts in (counter wraps 63->0), the word SHALL be pushed into the FIFO reordered as {s[15:0], s[31:16], s[47:32], s[63:48]}, s being the shift register including that pixel, so the first captured pixel sits at data[15].
REQ-008 On pix_de falling edge with counter != 0, the partial word SHALL be left-aligned, zero-padded to 64 pixels, reordered per REQ-007, pushed one pclk later; counter cleared.
REQ-009 A push with FIFO full SHALL drop the new word, leave FIFO contents unchanged and set overflow.
REQ-010 Write arming: on the first pclk with bus_cycle==1 after bus_cycle!=1, armed SHALL be set iff FIFO non-empty; write = (bus_cycle==1) & armed.
REQ-011 data SHALL equal the FIFO head and addr the current write pointer, both stable the entire time write=1.
REQ-012 Commit: on the pclk where bus_cycle==1, armed=1 and clk_8_en=1 while its previous-pclk value was 0, the FIFO SHALL pop, addr SHALL advance by 4, armed SHALL clear; at most one commit per slot.
REQ-013 Simultaneous push and pop SHALL both take effect; occupancy unchanged; a push with FIFO full and a pop in the same pclk SHALL be accepted (not an overflow).
REQ-014 Falling edge of pix_vs_n (registered-sample detection) SHALL: load addr with himem?BASE_HI:BASE, flush FIFO, clear counter, shift register, armed and overflow, pulse frame_done for one pclk; any pixel or push in that pclk is discarded.
REQ-015 If a vs edge falls inside an armed slot, write SHALL drop on the next pclk and no commit SHALL occur in that slot.
REQ-016 addr SHALL wrap modulo 2^23; FIFO pointers wrap modulo FIFO_DEPTH with a separate full/empty distinction.
REQ-017 Sustained rate: one word per 64 pix_de pixels against one slot-1 per 64 pclk SHALL run indefinitely without overflow at FIFO_DEPTH>=2.

Reset
REQ-018 While reset_n=0: addr=BASE, write=0, data=0, overflow=0, frame_done=0, FIFO empty, counter=0, armed=0; all state asynchronously cleared.
REQ-019 Reset deasserted mid-slot SHALL not arm until the next bus_cycle 1 entry.

Verification
REQ-020 Bench SHALL cover:
  - vs_n fall, himem=0, then 64 pixels alternating 1,0 from first -> one write, addr=0x600000, data=64'hAAAA_AAAA_AAAA_AAAA; next addr 0x600004.
  - 16 ones then 48 zeros -> data=64'h0000_0000_0000_FFFF.
  - 10 pixels of 1 then pix_de=0 -> data=64'h0000_0000_0000_FFC0, counter=0.
  - bus_cycle held !=1 during 5 full words, FIFO_DEPTH=4 -> overflow=1, 4 words later written in order, 5th absent.
  - vs_n fall during armed slot with 2 words queued, himem=1 -> write drops, FIFO empty, addr=0x740000, frame_done 1 pclk, overflow=0.
  - reset_n low mid-line with 3 words queued -> all outputs at reset values immediately, no write after release until new pixels.
